bitwise_unit: RTL

Parametrised, multi-cycle bitwise logic unit for the processor ALU. It generalises the fixed 32-bit AND stage to configurable width and an 8-operation set. Operands are processed in SLICE-bit chunks over several cycles behind a valid/ready handshake. The ALU uses it as a low-area logic path and holds the result until the consumer takes it.

---
 rtl/bitwise_pkg.sv | 30 +++
 rtl/bitwise_if.sv | 42 ++++
 rtl/bitwise_slice.sv | 29 ++
 rtl/bitwise_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared types and defaults for the multi-cycle bitwise logic unit.
// Optional flag outputs are enabled with BITWISE_FLAGS_EN.
package bitwise_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width: clog2 of the slice count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwise_if.sv
// Request/result handshake bundle for bitwise_unit.
// zero/parity are present only when BITWISE_FLAGS_EN is defined.
interface bitwise_if
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
`ifdef BITWISE_FLAGS_EN
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, out, zero, parity
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, out, zero, parity
  );
`else
  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, out
  );
`endif

endinterface

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit logic operation; one instance is time-shared
// across all slices of the operands.
module bitwise_slice
  import bitwise_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_t              op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_unit.sv
// Multi-cycle bitwise logic unit: latches A/B/op, computes one SLICE per
// cycle, then holds the result until taken. Flags via BITWISE_FLAGS_EN.
module bitwise_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic   clock,
  input  logic   reset_n,
  bitwise_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);
  localparam int NP = 2 ** CW;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  op_t              op_reg, op_next;
  logic [WIDTH-1:0] out_reg, out_next;

  logic [SLICE-1:0] a_sl [NP];
  logic [SLICE-1:0] b_sl [NP];
  logic [SLICE-1:0] y;
  logic [WIDTH-1:0] merged;

  // Operand slice tables padded to a power of two so the counter index is always in range.
  for (genvar gi = 0; gi < NP; gi++) begin : g_sel
    if (gi < N) begin : g_live
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
    end else begin : g_pad
      assign a_sl[gi] = '0;
      assign b_sl[gi] = '0;
    end
  end

  bitwise_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sl[cnt_reg]),
    .b  (b_sl[cnt_reg]),
    .op (op_reg),
    .y  (y)
  );

  // Result with the current slice replaced by the freshly computed one.
  for (genvar gi = 0; gi < N; gi++) begin : g_merge
    assign merged[gi*SLICE +: SLICE] =
      (cnt_reg == CW'(gi)) ? y : out_reg[gi*SLICE +: SLICE];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    out_next   = out_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.A;
          b_next     = bus.B;
          op_next    = bus.op;
          cnt_next   = '0;
          out_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        out_next = merged;
        if (cnt_reg == CNT_LAST) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_AND;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      out_reg   <= out_next;
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.out       = out_reg;

`ifdef BITWISE_FLAGS_EN
  logic zero_reg, zero_next;
  logic parity_reg, parity_next;

  // Flags come from the complete result on the last RUN edge and then hold.
  always_comb begin
    zero_next   = zero_reg;
    parity_next = parity_reg;
    if (state_reg == S_RUN && cnt_reg == CNT_LAST) begin
      zero_next   = (merged == '0);
      parity_next = ^merged;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_reg   <= 1'b1;
      parity_reg <= 1'b0;
    end else begin
      zero_reg   <= zero_next;
      parity_reg <= parity_next;
    end
  end

  assign bus.zero   = zero_reg;
  assign bus.parity = parity_reg;
`endif

endmodule
